// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the iterative binary-to-BCD converter.
//   BCD_NIBBLE     : bits per BCD digit
//   bcd_state_t    : converter FSM states (IDLE, SHIFT, DONE)
//   bcd_min_digits : smallest digit count able to hold 2^width-1
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam int BCD_NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    // ceil(width * log10(2)), with log10(2) taken as 0.30103. The fixed-point
    // approximation is exact for every width of practical interest.
    function automatic int bcd_min_digits(input int width);
        longint t;
        t = (longint'(width) * 64'sd30103 + 64'sd99999) / 64'sd100000;
        if (t < 1) begin
            return 1;
        end
        return int'(t);
    endfunction

endpackage

// File: rtl/bcd_seq_converter_if.sv
// -----------------------------------------------------------------------------
// bcd_seq_converter_if
// Handshake bundle around the converter.
//   in_valid/in_ready/in_data    : binary operand, valid/ready
//   out_valid/out_ready/bcd_data : packed BCD result, valid/ready
//   busy                         : conversion in progress
// master = producer/consumer side, slave = converter side.
// -----------------------------------------------------------------------------
interface bcd_seq_converter_if #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [IN_WIDTH-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_data;
    logic                  busy;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  bcd_data,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output bcd_data,
        output busy
    );

endinterface

// File: rtl/bcd_add3_stage.sv
// -----------------------------------------------------------------------------
// bcd_add3_stage
// Combinational double-dabble correction: every BCD nibble >= 5 gets +3
// (4-bit wrap, no carry between digits) so the following left shift carries
// correctly into the next decimal digit.
//   bcd_in  : DIGITS packed BCD nibbles before correction
//   bcd_out : corrected nibbles
// -----------------------------------------------------------------------------
module bcd_add3_stage
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic [BCD_NIBBLE*DIGITS-1:0] bcd_in,
    output logic [BCD_NIBBLE*DIGITS-1:0] bcd_out
);

    always_comb begin
        bcd_out = '0;
        for (int i = 0; i < DIGITS; i++) begin
            logic [BCD_NIBBLE-1:0] nib;
            nib = bcd_in[BCD_NIBBLE*i +: BCD_NIBBLE];
            if (nib >= 4'd5) begin
                bcd_out[BCD_NIBBLE*i +: BCD_NIBBLE] = nib + 4'd3;
            end else begin
                bcd_out[BCD_NIBBLE*i +: BCD_NIBBLE] = nib;
            end
        end
    end

endmodule

// File: rtl/bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// bcd_seq_converter
// Iterative binary-to-BCD converter (shift-add-3), one shift per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_seq_converter_if
//           (in_valid/in_ready/in_data, out_valid/out_ready/bcd_data, busy)
// An operand is accepted in IDLE, shifted IN_WIDTH times in SHIFT, then the
// result is held in DONE until the consumer takes it.
// -----------------------------------------------------------------------------
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_seq_converter_if.slave   bus
);

    localparam int BW = BCD_NIBBLE * DIGITS;
    localparam int SW = BW + IN_WIDTH;
    localparam int CW = $clog2(IN_WIDTH + 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_DONE  = DONE;

    generate
        if (DIGITS < bcd_min_digits(IN_WIDTH)) begin : g_digits_check
            $error("bcd_seq_converter: DIGITS=%0d too small for IN_WIDTH=%0d",
                   DIGITS, IN_WIDTH);
        end
    endgenerate

    logic [1:0]    state;
    logic [SW-1:0] sh;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bcd_q;
    logic          out_valid_q;

    logic [BW-1:0] bcd_fix;
    logic [SW-1:0] sh_next;

    // The single correction stage is reused on every iteration.
    bcd_add3_stage #(
        .DIGITS (DIGITS)
    ) u_add3 (
        .bcd_in  (sh[SW-1:IN_WIDTH]),
        .bcd_out (bcd_fix)
    );

    // Correct first, then shift the whole register left by one.
    always_comb begin
        logic [SW-1:0] corrected;
        corrected = {bcd_fix, sh[IN_WIDTH-1:0]};
        sh_next   = {corrected[SW-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sh          <= '0;
            cnt         <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        sh    <= {{BW{1'b0}}, bus.in_data};
                        cnt   <= CW'(IN_WIDTH);
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sh  <= sh_next;
                    cnt <= cnt - CW'(1);
                    // Last iteration: the counter hits zero on this edge.
                    if (cnt == CW'(1)) begin
                        bcd_q       <= sh_next[SW-1:IN_WIDTH];
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // in_ready and busy decode straight from the state register.
    assign bus.in_ready  = (state == S_IDLE);
    assign bus.busy      = (state == S_SHIFT);
    assign bus.out_valid = out_valid_q;
    assign bus.bcd_data  = bcd_q;

endmodule
